// File: rtl/mc_core.sv
// mc_core: multicycle CPU core sharing one memory port for fetch and data.
// Latency: R/ADDI/SW 4 cycles, LW 5, BEQ/J 3, plus one cycle per memory wait cycle.
// Backpressure: mem_req/we/addr/wdata come from state and registers and hold until mem_ready.
// Ports: clk, reset (async, active-low); mem_* request/ready port to unified memory;
//        pc, halted and state are status/debug outputs.
module mc_core #(
    parameter int            N        = 32,
    parameter int            NREG     = 128,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic [N-1:0] pc,
    output logic         halted,
    output logic [3:0]   state
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_ALUWB_R = 4'd4,
        S_EXEC_I  = 4'd5,
        S_ALUWB_I = 4'd6,
        S_MEMADR  = 4'd7,
        S_MEMRD   = 4'd8,
        S_MEMWB   = 4'd9,
        S_MEMWR   = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic [31:0]  r_ir;
    logic [N-1:0] r_mdr;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_aluout;
    logic [N-1:0] r_rf [NREG];

    logic [5:0]   w_op;
    logic [6:0]   w_rs;
    logic [6:0]   w_rt;
    logic [6:0]   w_rd;
    logic [N-1:0] w_simm;
    logic [N-1:0] w_boff;
    logic [N-1:0] w_rs_val;
    logic [N-1:0] w_rt_val;
    logic [N-1:0] w_alu;
    logic [N-1:0] w_diff;
    logic         w_wb_en;
    logic [6:0]   w_wb_idx;
    logic [N-1:0] w_wb_dat;

    assign w_op   = r_ir[31:26];
    assign w_rs   = r_ir[25:19];
    assign w_rt   = r_ir[18:12];
    assign w_rd   = r_ir[11:5];
    assign w_simm = {{(N-12){r_ir[11]}}, r_ir[11:0]};
    assign w_boff = {w_simm[N-3:0], 2'b00};
    assign w_diff = r_a - r_b;

    // Index 0 and indices beyond the implemented file read as zero.
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs != 7'd0 && int'(w_rs) < NREG) w_rs_val = r_rf[w_rs[AW-1:0]];
        if (w_rt != 7'd0 && int'(w_rt) < NREG) w_rt_val = r_rf[w_rt[AW-1:0]];
    end

    always_comb begin
        w_alu = '0;
        case (r_ir[3:0])
            4'b0000: w_alu = r_a & r_b;
            4'b0001: w_alu = r_a | r_b;
            4'b0010: w_alu = r_a + r_b;
            4'b0110: w_alu = r_a - r_b;
            4'b0111: w_alu = {{(N-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            4'b1100: w_alu = ~(r_a | r_b);
            default: w_alu = '0;
        endcase
    end

    // Write-back port: R-type targets rd, ADDI/LW target rt; r0 and out-of-range drop.
    always_comb begin
        w_wb_idx = (r_state == S_ALUWB_R) ? w_rd : w_rt;
        w_wb_dat = (r_state == S_MEMWB) ? r_mdr : r_aluout;
        w_wb_en  = (r_state == S_ALUWB_R || r_state == S_ALUWB_I || r_state == S_MEMWB)
                   && (w_wb_idx != 7'd0) && (int'(w_wb_idx) < NREG);
    end

    // Register file is deliberately not reset; reset forces START so no write-back fires.
    always_ff @(posedge clk) begin
        if (w_wb_en) r_rf[w_wb_idx[AW-1:0]] <= w_wb_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_START;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            case (r_state)
                S_START: r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata[31:0];
                        r_pc    <= r_pc + N'(4);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    // pc is already incremented here, so this is the branch target.
                    r_aluout <= r_pc + w_boff;
                    case (w_op)
                        OP_R:         r_state <= S_EXEC_R;
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_ADDI:      r_state <= S_EXEC_I;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_HALT:      r_state <= S_HALT;
                        default:      r_state <= S_HALT;
                    endcase
                end
                S_EXEC_R: begin
                    r_aluout <= w_alu;
                    r_state  <= S_ALUWB_R;
                end
                S_ALUWB_R: r_state <= S_FETCH;
                S_EXEC_I: begin
                    r_aluout <= r_a + w_simm;
                    r_state  <= S_ALUWB_I;
                end
                S_ALUWB_I: r_state <= S_FETCH;
                S_MEMADR: begin
                    r_aluout <= r_a + w_simm;
                    r_state  <= (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        r_mdr   <= mem_rdata;
                        r_state <= S_MEMWB;
                    end
                end
                S_MEMWB: r_state <= S_FETCH;
                S_MEMWR: begin
                    if (mem_ready) r_state <= S_FETCH;
                end
                S_BRANCH: begin
                    if (w_diff == '0) r_pc <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc    <= {r_pc[N-1:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Memory port is a pure decode of state and registers, never of mem_ready.
    assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign mem_we    = (r_state == S_MEMWR);
    assign mem_addr  = (r_state == S_FETCH) ? r_pc : r_aluout;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign state     = r_state;

endmodule

// File: tb/tb_mc_core.sv
module tb_mc_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic        halted;
    logic [3:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [1024];
    logic [63:0] sb_q [$];
    int          slow_wait  = 0;
    bit          idle_ready = 1'b0;
    int          lw_hold    = 0;

    localparam logic [31:0] HALT_W = 32'hFC000000;

    mc_core #(.N(32), .NREG(128), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [6:0] rs,
                                        input logic [6:0] rt, input logic [11:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] f_r(input logic [6:0] rs, input logic [6:0] rt,
                                        input logic [6:0] rd, input logic [3:0] fn);
        return {6'h00, rs, rt, rd, 1'b0, fn};
    endfunction

    task automatic load_fill();
        for (int i = 0; i < 1024; i++) mem[i] = HALT_W;
        sb_q.delete();
    endtask

    task automatic put(input int k, input logic [31:0] w);
        mem[64 + k] = w;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, output int edges);
        edges = 0;
        forever begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (halted === 1'b1) break;
            if (edges >= budget) break;
        end
    endtask

    // Memory model and store scoreboard; addresses 0x300-0x3FF answer after slow_wait waits.
    initial begin : memory_model
        int          wait_cnt;
        int          lat;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        logic [63:0] exp;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                wait_cnt  = 0;
                mem_ready = 1'b0;
            end else if (mem_req === 1'b1) begin
                if (wait_cnt == 0) begin
                    h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                end else begin
                    n_checks++;
                    if (mem_addr !== h_addr || mem_we !== h_we || (h_we && mem_wdata !== h_wdata)) begin
                        n_fail++;
                        $display("FAIL hold: addr=%h we=%b wdata=%h, held addr=%h we=%b wdata=%h",
                                 mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
                    end
                end
                lat = (mem_addr >= 32'h300 && mem_addr < 32'h400) ? slow_wait : 0;
                if (wait_cnt >= lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    if (lat > 0 && mem_we === 1'b0) lw_hold = wait_cnt + 1;
                    if (mem_we === 1'b1) begin
                        mem[mem_addr[11:2]] = mem_wdata;
                        n_checks++;
                        if (sb_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL store_unexpected: addr=%h data=%h, none expected", mem_addr, mem_wdata);
                        end else begin
                            exp = sb_q.pop_front();
                            if ({mem_addr, mem_wdata} !== exp)begin
                                n_fail++;
                                $display("FAIL store: addr=%h data=%h, expected addr=%h data=%h",
                                         mem_addr, mem_wdata, exp[63:32], exp[31:0]);
                            end
                        end
                    end
                    wait_cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ready = idle_ready;
                mem_rdata = $urandom;
                wait_cnt  = 0;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        load_fill();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h100 || mem_req !== 1'b0 || mem_we !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h req=%b we=%b halted=%b, expected pc=100 req=0 we=0 halted=0",
                     pc, mem_req, mem_we, halted);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle: req=%b, expected 0", mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL first_fetch: req=%b addr=%h we=%b, expected req=1 addr=100 we=0",
                     mem_req, mem_addr, mem_we);
        end
    endtask

    task automatic test_alu();
        int edges;
        reset = 1'b0;
        load_fill();
        slow_wait = 0;
        idle_ready = 1'b1;
        put(0,  f_i(6'h08, 7'd0, 7'd1, 12'd5));
        put(1,  f_i(6'h08, 7'd0, 7'd2, 12'hFFD));
        put(2,  f_r(7'd1, 7'd2, 7'd3, 4'h6));
        put(3,  f_r(7'd2, 7'd1, 7'd4, 4'h7));
        put(4,  f_i(6'h08, 7'd0, 7'd0, 12'd7));
        put(5,  f_r(7'd1, 7'd2, 7'd5, 4'h0));
        put(6,  f_r(7'd1, 7'd2, 7'd6, 4'hC));
        put(7,  f_i(6'h08, 7'd0, 7'd7, 12'd9));
        put(8,  f_r(7'd1, 7'd2, 7'd7, 4'h5));
        put(9,  f_r(7'd1, 7'd2, 7'd8, 4'h2));
        put(10, f_r(7'd1, 7'd2, 7'd9, 4'h1));
        put(11, f_i(6'h2B, 7'd0, 7'd3, 12'h200)); sb_q.push_back({32'h200, 32'd8});
        put(12, f_i(6'h2B, 7'd0, 7'd4, 12'h204)); sb_q.push_back({32'h204, 32'd1});
        put(13, f_i(6'h2B, 7'd0, 7'd0, 12'h208)); sb_q.push_back({32'h208, 32'd0});
        put(14, f_i(6'h2B, 7'd0, 7'd5, 12'h20C)); sb_q.push_back({32'h20C, 32'd5});
        put(15, f_i(6'h2B, 7'd0, 7'd6, 12'h210)); sb_q.push_back({32'h210, 32'd2});
        put(16, f_i(6'h2B, 7'd0, 7'd7, 12'h214)); sb_q.push_back({32'h214, 32'd0});
        put(17, f_i(6'h2B, 7'd0, 7'd2, 12'h218)); sb_q.push_back({32'h218, 32'hFFFFFFFD});
        put(18, f_i(6'h2B, 7'd0, 7'd8, 12'h21C)); sb_q.push_back({32'h21C, 32'd2});
        put(19, f_i(6'h2B, 7'd0, 7'd9, 12'h220)); sb_q.push_back({32'h220, 32'hFFFFFFFD});
        release_reset();
        run_to_halt(200, edges);
        n_checks++;
        if (edges != 83) begin
            n_fail++;
            $display("FAIL alu_cycles: %0d cycles to halt, expected 83", edges);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL alu_stores_missing: %0d stores outstanding, expected 0", sb_q.size());
        end
        idle_ready = 1'b0;
    endtask

    task automatic test_mem_wait();
        int edges;
        reset = 1'b0;
        load_fill();
        slow_wait = 3;
        lw_hold = 0;
        mem[192] = 32'hDEADBEEF;
        put(0, f_i(6'h23, 7'd0, 7'd10, 12'h300));
        put(1, f_i(6'h2B, 7'd0, 7'd10, 12'h208)); sb_q.push_back({32'h208, 32'hDEADBEEF});
        put(2, f_i(6'h2B, 7'd0, 7'd10, 12'h304)); sb_q.push_back({32'h304, 32'hDEADBEEF});
        release_reset();
        run_to_halt(100, edges);
        n_checks++;
        if (edges != 22) begin
            n_fail++;
            $display("FAIL mem_cycles: %0d cycles to halt, expected 22", edges);
        end
        n_checks++;
        if (lw_hold != 4) begin
            n_fail++;
            $display("FAIL lw_hold: request held %0d cycles, expected 4", lw_hold);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL mem_stores_missing: %0d stores outstanding, expected 0", sb_q.size());
        end
        slow_wait = 0;
    endtask

    task automatic test_control();
        int edges;
        reset = 1'b0;
        load_fill();
        put(0,  f_i(6'h08, 7'd0, 7'd1, 12'd1));
        put(1,  f_i(6'h08, 7'd0, 7'd2, 12'd2));
        put(2,  f_i(6'h04, 7'd1, 7'd2, 12'd5));
        put(3,  f_i(6'h04, 7'd1, 7'd1, 12'd1));
        put(4,  f_i(6'h2B, 7'd0, 7'd0, 12'h2F0));
        put(5,  f_i(6'h2B, 7'd0, 7'd1, 12'h200)); sb_q.push_back({32'h200, 32'd1});
        put(6,  {6'h02, 26'h60});
        put(7,  f_i(6'h2B, 7'd0, 7'd0, 12'h2F4));
        put(32, f_i(6'h2B, 7'd0, 7'd2, 12'h204)); sb_q.push_back({32'h204, 32'd2});
        release_reset();
        run_to_halt(100, edges);
        n_checks++;
        if (edges != 28) begin
            n_fail++;
            $display("FAIL ctrl_cycles: %0d cycles to halt, expected 28", edges);
        end
        n_checks++;
        if (pc !== 32'h188) begin
            n_fail++;
            $display("FAIL ctrl_pc: pc=%h, expected 188", pc);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL ctrl_stores_missing: %0d stores outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_loops();
        logic [31:0] prog [2];
        prog[0] = {6'h02, 26'h40};
        prog[1] = f_i(6'h04, 7'd0, 7'd0, 12'hFFF);
        idle_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            reset = 1'b0;
            load_fill();
            put(0, prog[p]);
            release_reset();
            repeat (13) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (pc !== 32'h100 || mem_req !== 1'b1 || mem_addr !== 32'h100 || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL loop%0d: pc=%h req=%b addr=%h halted=%b, expected pc=100 req=1 addr=100 halted=0",
                         p, pc, mem_req, mem_addr, halted);
            end
        end
        idle_ready = 1'b0;
    endtask

    task automatic test_halt();
        logic [5:0] ops [2];
        int edges;
        int reqs;
        ops[0] = 6'h15;
        ops[1] = 6'h3F;
        for (int p = 0; p < 2; p++) begin
            reset = 1'b0;
            load_fill();
            put(0, {ops[p], 26'h0});
            put(1, f_i(6'h2B, 7'd0, 7'd0, 12'h200));
            release_reset();
            run_to_halt(20, edges);
            n_checks++;
            if (edges != 3 || pc !== 32'h104) begin
                n_fail++;
                $display("FAIL halt_op%h: cycles=%0d pc=%h, expected cycles=3 pc=104", ops[p], edges, pc);
            end
            reqs = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (mem_req === 1'b1 || halted !== 1'b1) reqs++;
            end
            n_checks++;
            if (reqs != 0) begin
                n_fail++;
                $display("FAIL halt_quiet_op%h: %0d cycles with req or not halted, expected 0", ops[p], reqs);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  edges;
        bit  found;
        reset = 1'b0;
        load_fill();
        slow_wait = 3;
        mem[192] = 32'hDEADBEEF;
        put(0, f_i(6'h08, 7'd0, 7'd5, 12'd7));
        put(1, f_i(6'h23, 7'd0, 7'd5, 12'h300));
        release_reset();
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_addr === 32'h300) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reach_memrd: load request not seen, expected by 30 cycles");
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || pc !== 32'h100) begin
            n_fail++;
            $display("FAIL mid_async: req=%b pc=%h, expected req=0 pc=100", mem_req, pc);
        end
        put(0, f_i(6'h2B, 7'd0, 7'd5, 12'h204)); sb_q.push_back({32'h204, 32'd7});
        put(1, HALT_W);
        release_reset();
        run_to_halt(50, edges);
        n_checks++;
        if (edges != 7) begin
            n_fail++;
            $display("FAIL mid_restart_cycles: %0d cycles to halt, expected 7", edges);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_stores_missing: %0d stores outstanding, expected 0", sb_q.size());
        end
        slow_wait = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_control();
        test_loops();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
